// File: rtl/ram_master_pkg.sv
// Shared encodings for the MEM-stage RAM initiator: access sizes, FSM states and
// the SRAM driver handshake levels.
package ram_master_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StGap  = 3'd2,
    StWr   = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic        RAMWrite_OP = 1'b1;
  localparam logic        RAMRead_OP  = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Encoding 2'b11 is served as a word access.
  function automatic size_e norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SizeWord : size_e'(size);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (norm_size(size))
      SizeHalf: return addr_lo[0];
      SizeWord: return addr_lo != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Little-endian byte-lane steering: extracts/extends sub-word loads and merges
// sub-word store data into a previously read word.
module ram_lane_align
  import ram_master_pkg::*;
(
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] shifted;

  always_comb begin
    sh       = 5'd0;
    mask     = 32'hFFFF_FFFF;
    load_val = rword;
    case (size)
      SizeByte: begin
        sh   = {lane, 3'b000};
        mask = 32'h0000_00FF << sh;
      end
      SizeHalf: begin
        sh   = {lane[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
      end
      default: ;
    endcase
    shifted = rword >> sh;
    case (size)
      SizeByte: load_val = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SizeHalf: load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:  load_val = rword;
    endcase
    merged = (rword & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/ram_master.sv
// MEM-stage load/store initiator for the word-wide SRAM driver; sub-word stores
// are done as read, one-cycle disable gap, then write of the merged word.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ready_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic              sign_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_data_q;

  logic              req_mis;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign req_mis = misaligned(size_i, addr_i[1:0]);

  ram_lane_align u_align (
    .size     (size_q),
    .sign_ext (sign_q),
    .lane     (addr_q[1:0]),
    .rword    (ram_data_i),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          if (req_mis)                                  state_d = StErr;
          else if (wr_i && norm_size(size_i) == SizeWord) state_d = StWr;
          else                                          state_d = StRd;
        end
      end
      StRd:   if (ram_ready_i) state_d = wr_q ? StGap : StDone;
      // Driver drops its stale read ready only while disabled.
      StGap:  state_d = StWr;
      StWr:   if (ram_ready_i) state_d = StDone;
      StDone: state_d = StIdle;
      StErr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= SizeWord;
      sign_q     <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= ZeroWord;
      ram_data_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_i) begin
        addr_q  <= addr_i;
        size_q  <= norm_size(size_i);
        sign_q  <= signed_i;
        wr_q    <= wr_i;
        wdata_q <= wdata_i;
        if (wr_i && norm_size(size_i) == SizeWord && !req_mis) ram_data_q <= wdata_i;
      end
      if (state_q == StRd && ram_ready_i) begin
        if (wr_q) ram_data_q <= merged;
        else      rdata_q    <= load_val;
      end
    end
  end

  always_comb begin
    ram_ce_o   = (state_q == StRd || state_q == StWr) ? ChipEnable : ChipDisable;
    ram_we_o   = (state_q == StWr) ? RAMWrite_OP : RAMRead_OP;
    ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    ram_data_o = ram_data_q;
    rdata_o    = rdata_q;
    done_o     = (state_q == StDone) || (state_q == StErr);
    err_o      = (state_q == StErr);
    stall_o    = req_i && (state_q != StDone) && !(state_q == StIdle && req_mis);
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural SRAM driver: ready one cycle
// after enable for writes, two cycles for reads, cleared only while disabled.
module tb_ram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done, err, stall;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_dout, ram_din;
  logic        ram_rdy;

  logic [31:0] mem [0:63];
  logic [1:0]  cnt;
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0, poke_data = '0;

  int total = 0;
  int bad = 0;

  int          lat;
  logic [31:0] r_rdata, wr_addr, wr_data;
  logic        r_err, ce_seen, stall_t0, stall_done;
  int          gap_cnt;

  always #5 clk = ~clk;

  ram_master dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .wr_i        (wr),
    .size_i      (size),
    .signed_i    (sgn),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .done_o      (done),
    .err_o       (err),
    .stall_o     (stall),
    .ram_ce_o    (ram_ce),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_dout),
    .ram_data_i  (ram_din),
    .ram_ready_i (ram_rdy)
  );

  assign ram_din = mem[ram_addr[7:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 2'd0;
      ram_rdy <= 1'b0;
    end else begin
      if (poke_en) mem[poke_addr[7:2]] <= poke_data;
      if (!ram_ce) begin
        cnt     <= 2'd0;
        ram_rdy <= 1'b0;
      end else begin
        if (cnt != 2'd3) cnt <= cnt + 2'd1;
        ram_rdy <= ram_we ? 1'b1 : (cnt >= 2'd1);
        if (ram_we && ram_rdy) mem[ram_addr[7:2]] <= ram_dout;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic start(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req = 1'b1; wr = w; size = sz; sgn = sg; addr = a; wdata = wd;
  endtask

  // Cycle index 0 is the accept cycle.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    start(w, sz, sg, a, wd);
    lat = -1; ce_seen = 1'b0; gap_cnt = 0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) stall_t0 = stall;
      if (ram_ce) ce_seen = 1'b1;
      else if (ce_seen && !done) gap_cnt++;
      if (ram_ce && ram_we) begin
        wr_addr = ram_addr;
        wr_data = ram_dout;
      end
      if (done) begin
        lat = i; r_rdata = rdata; r_err = err; stall_done = stall;
        break;
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    #23;
    check("rst_ce", 32'(ram_ce), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_wdata", ram_dout, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("wst_lat", 32'(lat), 32'd3);
    check("wst_addr", wr_addr, 32'h10);
    check("wst_data", wr_data, 32'hDEADBEEF);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    check("wst_err", 32'(r_err), 32'd0);

    // Byte store, read-modify-write with gap
    poke(32'h10, 32'h11223344);
    run_txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA);
    check("bst_lat", 32'(lat), 32'd7);
    check("bst_gap", 32'(gap_cnt), 32'd1);
    check("bst_data", wr_data, 32'hAA223344);
    check("bst_mem", mem[4], 32'hAA223344);

    // Halfword store into upper half
    poke(32'h10, 32'h11223344);
    run_txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
    check("hst_lat", 32'(lat), 32'd7);
    check("hst_mem", mem[4], 32'hBEEF3344);

    // Byte loads
    poke(32'h10, 32'h11228344);
    run_txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lbs_lat", 32'(lat), 32'd4);
    check("lbs_data", r_rdata, 32'hFFFFFF83);
    check("lbs_stall_t0", 32'(stall_t0), 32'd1);
    check("lbs_stall_done", 32'(stall_done), 32'd0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("lbu_data", r_rdata, 32'h00000083);

    // Halfword load and misaligned halfword
    poke(32'h10, 32'h8001FFFF);
    run_txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lhs_data", r_rdata, 32'hFFFF8001);
    run_txn(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", 32'(r_err), 32'd1);
    check("mis_ce", 32'(ce_seen), 32'd0);
    check("mis_rdata", r_rdata, 32'hFFFF8001);
    check("mis_stall_t0", 32'(stall_t0), 32'd0);

    // Size 11 acts as word
    run_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("lw11_lat", 32'(lat), 32'd4);
    check("lw11_data", r_rdata, 32'h8001FFFF);

    // Reset mid-cycle during a read
    start(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk); @(negedge clk);
    check("mid_ce_before", 32'(ram_ce), 32'd1);
    #2;
    rst = 1'b1; req = 1'b0;
    #1;
    check("mid_ce", 32'(ram_ce), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_rdata", rdata, 32'h0);
    check("mid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the gap of a byte store
    poke(32'h10, 32'h11223344);
    start(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA);
    ce_seen = 1'b0;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ram_ce) ce_seen = 1'b1;
        else if (ce_seen) begin
          hit = 1'b1;
          break;
        end
      end
      check("gap_found", 32'(hit), 32'd1);
    end
    rst = 1'b1; req = 1'b0;
    #1;
    check("gap_rst_ce", 32'(ram_ce), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("gap_mem", mem[4], 32'h11223344);
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("post_lat", 32'(lat), 32'd4);
    check("post_data", r_rdata, 32'h11223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
